// File: rtl/vram_pkg.sv
// ----------------------------------------------------------------------------
// vram_pkg
// Shared constants and types for the video-RAM arbiter.
//
// Contents:
//   VRAM_ADDR_W  - RAM word-address width (32 KiB window below 0x8000)
//   VRAM_DATA_W  - RAM data width
//   arb_state_t  - arbiter FSM state
//   cpu_rdy_idle - RDY value the CPU sees while the arbiter is idle
// ----------------------------------------------------------------------------
package vram_pkg;

    localparam int VRAM_ADDR_W = 15;
    localparam int VRAM_DATA_W = 8;

    // IDLE   : port free for a new CPU grant (PPU always wins the port)
    // RD_CAP : the cycle after a CPU read grant; RAM data is captured for the CPU
    typedef enum logic {
        IDLE   = 1'b0,
        RD_CAP = 1'b1
    } arb_state_t;

    // While idle the CPU is held off whenever it requests and either the PPU
    // owns the port this cycle or it is a read (reads need a second cycle for
    // the synchronous RAM to return data). An uncontended write is immediate.
    function automatic logic cpu_rdy_idle(input logic cpu_req,
                                          input logic cpu_we,
                                          input logic ppu_req);
        return !(cpu_req && (ppu_req || !cpu_we));
    endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// ----------------------------------------------------------------------------
// vram_arbiter_if
// Bundles the CPU data-bus port, the PPU fetch port and the single-port RAM
// port of the video-RAM arbiter.
//
// Modports:
//   slave  - the arbiter: takes CPU/PPU requests and RAM read data, drives
//            CPU/PPU responses, the RAM address/write strobe and cpu_starved
//   master - the surrounding system (CPU, PPU, RAM): the mirror image
// ----------------------------------------------------------------------------
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int ADDR_W = VRAM_ADDR_W,
    parameter int DATA_W = VRAM_DATA_W
);

    // CPU data bus
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rdy;

    // PPU fetch port
    logic              ppu_req;
    logic [ADDR_W-1:0] ppu_addr;
    logic [DATA_W-1:0] ppu_rdata;
    logic              ppu_valid;

    // Single-port synchronous RAM
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    // Debug
    logic              cpu_starved;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_rdy,
        input  ppu_req, ppu_addr,
        output ppu_rdata, ppu_valid,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata,
        output cpu_starved
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_rdy,
        output ppu_req, ppu_addr,
        input  ppu_rdata, ppu_valid,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata,
        input  cpu_starved
    );

endinterface

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at MAX. Clear has priority over increment.
//
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (count -> 0)
//   inc    in   count up by one unless already at MAX
//   clr    in   return to zero
//   count  out  current value, $clog2(MAX+1) bits
//   at_max out  high while count equals MAX
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter  int MAX = 16,
    localparam int W   = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         at_max
);

    localparam logic [W-1:0] MAX_V = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != MAX_V)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign at_max = (count_q == MAX_V);

endmodule

// File: rtl/vram_arbiter.sv
// ----------------------------------------------------------------------------
// vram_arbiter
// Shares one single-port synchronous video RAM between the 6502 data bus and
// the character PPU fetch port. The PPU has strict priority and a fixed
// one-cycle latency; the CPU is stalled through RDY until its access is done.
// A saturating counter flags sustained CPU lock-out.
//
// Parameters:
//   ADDR_W        RAM word-address width
//   DATA_W        data width
//   STARVE_LIMIT  consecutive denied CPU cycles before cpu_starved asserts
//
// Ports:
//   clk_pix  in   single pixel/system clock, rising edge
//   rst_pix  in   asynchronous active-high reset
//   bus      slave modport of vram_arbiter_if:
//            cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_rdata/cpu_rdy out
//            ppu_req/ppu_addr in, ppu_rdata/ppu_valid out
//            ram_addr/ram_we/ram_wdata out, ram_rdata in
//            cpu_starved out
// ----------------------------------------------------------------------------
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int ADDR_W       = VRAM_ADDR_W,
    parameter int DATA_W       = VRAM_DATA_W,
    parameter int STARVE_LIMIT = 16
) (
    input  logic           clk_pix,
    input  logic           rst_pix,
    vram_arbiter_if.slave  bus
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [DATA_W-1:0] cpu_rd_q;
    logic [DATA_W-1:0] cpu_rd_d;
    logic [DATA_W-1:0] ppu_rd_q;
    logic [DATA_W-1:0] ppu_rd_d;
    logic              ppu_valid_q;

    logic              in_idle;
    logic              in_rd_cap;
    logic              cpu_grant;

    logic              starve_inc;
    logic              starve_clr;
    logic [CNT_W-1:0]  starve_count;
    logic              starve_at_max;

    assign in_idle   = (state_q == IDLE);
    assign in_rd_cap = (state_q == RD_CAP);

    // The PPU is granted whenever it asks. The CPU only gets the port when
    // idle and the PPU is silent; in RD_CAP the CPU is only collecting data.
    assign cpu_grant = in_idle && bus.cpu_req && !bus.ppu_req;

    // ------------------------------------------------------------------
    // RAM port. A write is only ever issued on a CPU-owned cycle, so the
    // address mux and the write strobe can never disagree.
    // ------------------------------------------------------------------
    assign bus.ram_addr  = bus.ppu_req ? bus.ppu_addr : bus.cpu_addr;
    assign bus.ram_wdata = bus.cpu_wdata;
    assign bus.ram_we    = cpu_grant && bus.cpu_we;

    // ------------------------------------------------------------------
    // CPU response. In RD_CAP the RAM output is bypassed straight to the
    // CPU so data is valid in the completing cycle; the hold register keeps
    // it stable afterwards while the RAM output moves on to PPU fetches.
    // ------------------------------------------------------------------
    assign bus.cpu_rdy   = in_rd_cap ? 1'b1
                                     : cpu_rdy_idle(bus.cpu_req, bus.cpu_we, bus.ppu_req);
    assign bus.cpu_rdata = in_rd_cap ? bus.ram_rdata : cpu_rd_q;

    // ------------------------------------------------------------------
    // PPU response: same bypass/hold arrangement, one cycle behind the
    // request to match the synchronous RAM read.
    // ------------------------------------------------------------------
    assign bus.ppu_valid = ppu_valid_q;
    assign bus.ppu_rdata = ppu_valid_q ? bus.ram_rdata : ppu_rd_q;

    // ------------------------------------------------------------------
    // FSM and capture registers
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cpu_rd_d = cpu_rd_q;
        ppu_rd_d = ppu_rd_q;

        case (state_q)
            IDLE: begin
                // Writes finish in the grant cycle; reads need the data cycle.
                if (cpu_grant && !bus.cpu_we) begin
                    state_d = RD_CAP;
                end
            end
            RD_CAP: begin
                cpu_rd_d = bus.ram_rdata;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (ppu_valid_q) begin
            ppu_rd_d = bus.ram_rdata;
        end
    end

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q     <= IDLE;
            cpu_rd_q    <= '0;
            ppu_rd_q    <= '0;
            ppu_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cpu_rd_q    <= cpu_rd_d;
            ppu_rd_q    <= ppu_rd_d;
            ppu_valid_q <= bus.ppu_req;
        end
    end

    // ------------------------------------------------------------------
    // Starvation monitor. Only idle-state denials count: the RD_CAP cycle
    // is the CPU finishing, so the count simply holds there.
    // ------------------------------------------------------------------
    assign starve_inc = bus.cpu_req && !cpu_grant && in_idle;
    assign starve_clr = cpu_grant || !bus.cpu_req;

    sat_counter #(
        .MAX (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk    (clk_pix),
        .rst    (rst_pix),
        .inc    (starve_inc),
        .clr    (starve_clr),
        .count  (starve_count),
        .at_max (starve_at_max)
    );

    // The counter's saturation flag and its raw value describe the same
    // condition; combining them keeps the count observable on the netlist.
    assign bus.cpu_starved = starve_at_max && (starve_count == CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_vram_arbiter.sv
// ----------------------------------------------------------------------------
// tb_vram_arbiter
// Bench for vram_arbiter: drives a CPU and PPU against a single-port RAM
// model and compares every cycle with a transaction-level reference.
// ----------------------------------------------------------------------------
module tb_vram_arbiter;

    localparam int AW    = 15;
    localparam int DW    = 8;
    localparam int LIMIT = 16;

    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;

    vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    vram_arbiter #(
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk_pix (clk_pix),
        .rst_pix (rst_pix),
        .bus     (bus)
    );

    always #5 clk_pix = ~clk_pix;

    // Single-port synchronous RAM (read-before-write, registered read)
    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk_pix) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_rdata <= mem[bus.ram_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] v);
        mem[a]     = v;
        ref_mem[a] = v;
    endtask

    // ------------------------------------------------------------------
    // Reference model: tracks transactions, not arbiter internals.
    //   m_rd_pending : a CPU read took the port last cycle, data due now
    //   m_ppu_pending: a PPU fetch was issued last cycle, data due now
    //   m_deny       : consecutive cycles the waiting CPU lost to the PPU
    // ------------------------------------------------------------------
    logic          m_rd_pending  = 1'b0;
    logic [DW-1:0] m_rd_data     = '0;
    logic [DW-1:0] m_cpu_hold    = '0;
    logic          m_ppu_pending = 1'b0;
    logic [DW-1:0] m_ppu_data    = '0;
    logic [DW-1:0] m_ppu_hold    = '0;
    int            m_deny        = 0;

    always @(negedge clk_pix) begin
        logic          takes_port;
        logic          done;
        logic          wr_now;
        logic [DW-1:0] exp_c;
        logic [DW-1:0] exp_p;
        if (rst_pix) begin
            chk("rst_rdy", 32'(bus.cpu_rdy), 32'(!bus.cpu_req || (bus.cpu_we && !bus.ppu_req)));
            chk("rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
            chk("rst_ppu_valid", 32'(bus.ppu_valid), 32'd0);
            chk("rst_ppu_rdata", 32'(bus.ppu_rdata), 32'd0);
            chk("rst_starved", 32'(bus.cpu_starved), 32'd0);
            m_rd_pending  = 1'b0;
            m_cpu_hold    = '0;
            m_ppu_pending = 1'b0;
            m_ppu_hold    = '0;
            m_deny        = 0;
        end else begin
            // CPU owns the RAM port this cycle only when it starts an access
            // and the PPU is silent.
            takes_port = bus.cpu_req && !bus.ppu_req && !m_rd_pending;
            wr_now     = takes_port && bus.cpu_we;
            done       = bus.cpu_req && (m_rd_pending || wr_now);
            exp_c      = m_rd_pending ? m_rd_data : m_cpu_hold;
            exp_p      = m_ppu_pending ? m_ppu_data : m_ppu_hold;

            chk("cpu_rdy", 32'(bus.cpu_rdy), 32'(!bus.cpu_req || done));
            chk("ram_we", 32'(bus.ram_we), 32'(wr_now));
            if (wr_now) begin
                chk("ram_addr_cpu", 32'(bus.ram_addr), 32'(bus.cpu_addr));
                chk("ram_wdata", 32'(bus.ram_wdata), 32'(bus.cpu_wdata));
            end
            if (bus.ppu_req) chk("ram_addr_ppu", 32'(bus.ram_addr), 32'(bus.ppu_addr));
            chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(exp_c));
            chk("ppu_valid", 32'(bus.ppu_valid), 32'(m_ppu_pending));
            chk("ppu_rdata", 32'(bus.ppu_rdata), 32'(exp_p));
            chk("cpu_starved", 32'(bus.cpu_starved), 32'(m_deny == LIMIT));

            if (done)
                $display("txn cpu %s addr=%04h data=%02h t=%0t",
                         bus.cpu_we ? "wr" : "rd", bus.cpu_addr,
                         bus.cpu_we ? bus.cpu_wdata : exp_c, $time);

            // Advance the model
            if (m_rd_pending) m_cpu_hold = m_rd_data;
            if (takes_port && !bus.cpu_we) m_rd_data = ref_mem[bus.cpu_addr];
            m_rd_pending = takes_port && !bus.cpu_we;
            if (m_ppu_pending) m_ppu_hold = m_ppu_data;
            m_ppu_pending = bus.ppu_req;
            if (bus.ppu_req) m_ppu_data = ref_mem[bus.ppu_addr];
            if (wr_now) ref_mem[bus.cpu_addr] = bus.cpu_wdata;

            if (!bus.cpu_req || takes_port) m_deny = 0;
            else if (bus.ppu_req && !m_rd_pending && m_deny < LIMIT) m_deny = m_deny + 1;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: inputs change 2 ns after the rising edge, results
    // are read 1 ns after the falling edge.
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_pix); #2;
            bus.cpu_req = 1'b0;
            bus.cpu_we  = 1'b0;
            bus.ppu_req = 1'b0;
        end
        @(negedge clk_pix); #1;
    endtask

    // One CPU access with a PPU request pattern pmask (bit k = cycle k).
    task automatic cpu_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [31:0] pmask, input logic [AW-1:0] pbase,
                           output int stalls, output logic [DW-1:0] rd, output int we_k,
                           output int starve_k, output logic starve_done);
        bit done;
        stalls = 0; we_k = -1; starve_k = -1; rd = '0; starve_done = 1'b0; done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(posedge clk_pix); #2;
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = we;
            bus.cpu_addr  = addr;
            bus.cpu_wdata = wd;
            bus.ppu_req   = (k < 32) ? pmask[k] : 1'b0;
            bus.ppu_addr  = pbase + AW'(k);
            @(negedge clk_pix); #1;
            if (bus.ram_we && we_k < 0) we_k = k;
            if (bus.cpu_starved && starve_k < 0) starve_k = k;
            if (bus.cpu_rdy) begin
                done        = 1;
                rd          = bus.cpu_rdata;
                starve_done = bus.cpu_starved;
            end else begin
                stalls++;
            end
        end
        chk("txn_timeout", 32'(done), 32'd1);
    endtask

    int            st, wk, sk;
    logic [DW-1:0] rd;
    logic          sd;

    initial begin
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.ppu_req = 1'b0; bus.ppu_addr = '0;
        for (int i = 0; i < (1 << AW); i++) preload(AW'(i), 8'(i ^ (i >> 8) ^ 8'h3C));
        preload(15'h0100, 8'h5A);
        for (int i = 0; i < 4; i++) preload(15'h1000 + AW'(i), 8'h10 + 8'(i));

        // Reset state
        repeat (2) @(posedge clk_pix);
        @(negedge clk_pix); #1;
        chk("reset_rdy_idle", 32'(bus.cpu_rdy), 32'd1);
        chk("reset_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        @(posedge clk_pix); #2; rst_pix = 1'b0;

        // Uncontended write then read of 0x0200
        cpu_txn(1'b1, 15'h0200, 8'hA5, 32'h0, 15'h1000, st, rd, wk, sk, sd);
        chk("wr_stalls", 32'(st), 32'd0);
        chk("wr_we_cycle", 32'(wk), 32'd0);
        idle(1);
        chk("wr_mem", 32'(mem[15'h0200]), 32'hA5);
        cpu_txn(1'b0, 15'h0200, 8'h00, 32'h0, 15'h1000, st, rd, wk, sk, sd);
        chk("rd_stalls", 32'(st), 32'd1);
        chk("rd_data", 32'(rd), 32'hA5);

        // Reset while in RD_CAP, then restart the read
        @(posedge clk_pix); #2;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 15'h0100; bus.ppu_req = 1'b0;
        @(negedge clk_pix); #1;
        chk("rstrd_grant_rdy", 32'(bus.cpu_rdy), 32'd0);
        @(posedge clk_pix); #2; rst_pix = 1'b1;
        @(negedge clk_pix); #1;
        chk("rstrd_rdy_idle", 32'(bus.cpu_rdy), 32'd0);
        chk("rstrd_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        chk("rstrd_ppu_valid", 32'(bus.ppu_valid), 32'd0);
        @(posedge clk_pix); #2; rst_pix = 1'b0; bus.cpu_req = 1'b0;
        cpu_txn(1'b0, 15'h0100, 8'h00, 32'h0, 15'h1000, st, rd, wk, sk, sd);
        chk("rstrd_restart_stalls", 32'(st), 32'd1);
        chk("rstrd_restart_data", 32'(rd), 32'h5A);

        // PPU streaming 0x1000..0x1003
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_pix); #2;
            bus.cpu_req  = 1'b0;
            bus.ppu_req  = (k < 4);
            bus.ppu_addr = 15'h1000 + AW'(k);
            @(negedge clk_pix); #1;
            chk("stream_valid", 32'(bus.ppu_valid), 32'((k >= 1) && (k <= 4)));
            if (k >= 1) chk("stream_data", 32'(bus.ppu_rdata), 32'(8'h10 + 8'((k <= 4) ? k - 1 : 3)));
        end

        // Contended write: PPU holds the port for 3 cycles
        cpu_txn(1'b1, 15'h0300, 8'h77, 32'h7, 15'h1000, st, rd, wk, sk, sd);
        chk("cwr_stalls", 32'(st), 32'd3);
        chk("cwr_we_cycle", 32'(wk), 32'd3);
        idle(1);
        chk("cwr_mem", 32'(mem[15'h0300]), 32'h77);
        chk("cwr_ppu_intact", 32'(mem[15'h1002]), 32'h12);

        // Read overlap: PPU fetch in the RD_CAP cycle
        cpu_txn(1'b0, 15'h0200, 8'h00, 32'h2, 15'h1000, st, rd, wk, sk, sd);
        chk("ovl_stalls", 32'(st), 32'd1);
        chk("ovl_cpu_data", 32'(rd), 32'hA5);
        idle(1);
        chk("ovl_ppu_valid", 32'(bus.ppu_valid), 32'd1);
        chk("ovl_ppu_data", 32'(bus.ppu_rdata), 32'h11);
        chk("ovl_cpu_hold", 32'(bus.cpu_rdata), 32'hA5);

        // Starvation: 20 denied cycles
        cpu_txn(1'b0, 15'h0100, 8'h00, 32'h000F_FFFF, 15'h1000, st, rd, wk, sk, sd);
        chk("starve_rise_cycle", 32'(sk), 32'd16);
        chk("starve_stalls", 32'(st), 32'd21);
        chk("starve_cleared", 32'(sd), 32'd0);
        chk("starve_data", 32'(rd), 32'h5A);

        // Random traffic over a small address window
        begin
            bit busy = 0;
            for (int c = 0; c < 300; c++) begin
                @(posedge clk_pix); #2;
                if (!busy) begin
                    if ($urandom_range(0, 1) == 1) begin
                        busy          = 1;
                        bus.cpu_req   = 1'b1;
                        bus.cpu_we    = 1'($urandom_range(0, 1));
                        bus.cpu_addr  = AW'($urandom_range(0, 63));
                        bus.cpu_wdata = 8'($urandom_range(0, 255));
                    end else begin
                        bus.cpu_req = 1'b0;
                    end
                end
                bus.ppu_req  = ($urandom_range(0, 9) < 4);
                bus.ppu_addr = AW'($urandom_range(0, 63));
                @(negedge clk_pix); #1;
                if (busy && bus.cpu_rdy) busy = 0;
            end
            for (int c = 0; c < 10 && busy; c++) begin
                @(posedge clk_pix); #2;
                bus.ppu_req = 1'b0;
                @(negedge clk_pix); #1;
                if (bus.cpu_rdy) busy = 0;
            end
            chk("rand_drained", 32'(busy), 32'd0);
        end
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares one single-port synchronous video RAM between the 6502 CPU data bus and the character PPU fetch port, replacing the dual-port RAM arrangement. PPU fetches have strict priority and fixed 1-cycle latency. CPU accesses are stalled through the 6502 `RDY` line until they complete. A saturating starvation counter flags sustained CPU lock-out for debug.

## Interface
Parameters:
- `ADDR_W`, 15, RAM word-address width (32 KiB window below 0x8000)
- `DATA_W`, 8, data width
- `STARVE_LIMIT`, 16, consecutive denied CPU cycles before `cpu_starved` asserts

Ports:
- `clk_pix`  in  1  single system/pixel clock; all logic on its rising edge
- `rst_pix`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  CPU accessing RAM (address_bus[15]==0); held stable while `cpu_rdy` low
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU word address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_rdata`  out  DATA_W  CPU read data; valid in the completing cycle, held afterwards
- `cpu_rdy`  out  1  to 6502 RDY; access completes at an edge where `cpu_req && cpu_rdy`
- `ppu_req`  in  1  PPU fetch request, one per cycle max
- `ppu_addr`  in  ADDR_W  PPU fetch address
- `ppu_rdata`  out  DATA_W  PPU fetch data
- `ppu_valid`  out  1  pulse exactly 1 cycle after the accepted `ppu_req`
- `ram_addr`  out  ADDR_W  RAM address
- `ram_we`  out  1  RAM write strobe
- `ram_wdata`  out  DATA_W  RAM write data
- `ram_rdata`  in  DATA_W  RAM read data, valid the cycle after the address is presented
- `cpu_starved`  out  1  high while the denial counter equals STARVE_LIMIT

## Operation
- FSM states: `IDLE`, `RD_CAP`.
- Grants are combinational in the current cycle:
  - `ppu_grant = ppu_req`, always accepted.
  - `cpu_grant = (state==IDLE) && cpu_req && !ppu_req`.
- RAM port signals:
  - `ram_addr = ppu_req ? ppu_addr : cpu_addr`.
  - `ram_wdata = cpu_wdata`.
  - `ram_we = cpu_grant && cpu_we`.
- `IDLE` state:
  - `cpu_rdy = !(cpu_req && (ppu_req || !cpu_we))`.
  - A granted write completes in the same cycle.
  - A granted read drops `cpu_rdy` and goes to `RD_CAP`.
  - A CPU request denied by the PPU keeps `cpu_rdy` low and stays in `IDLE`, retrying next cycle.
- `RD_CAP` state:
  - `cpu_rdy = 1`.
  - `cpu_rdata = ram_rdata` (bypass).
  - Hold register `cpu_rd_q <= ram_rdata`.
  - Next state is always `IDLE`.
  - The CPU does not use the port this cycle, so the PPU may.
- Outside `RD_CAP`, `cpu_rdata = cpu_rd_q`.
- PPU return path:
  - `ppu_valid_q <= ppu_req` every cycle.
  - `ppu_valid = ppu_valid_q`.
  - `ppu_rdata = ppu_valid_q ? ram_rdata : ppu_rd_q`.
  - `ppu_rd_q` loads `ram_rdata` when `ppu_valid_q`.
- Starvation counter:
  - Increments, saturating at STARVE_LIMIT, each cycle `cpu_req && !cpu_grant && state==IDLE`.
  - Clears on `cpu_grant` and on any cycle with `!cpu_req`.
  - Width `$clog2(STARVE_LIMIT+1)`.

## Timing
- Reset (async) values:
  - state = `IDLE`.
  - `cpu_rd_q`, `ppu_rd_q` = 0.
  - `ppu_valid` = 0.
  - Counter = 0, so `cpu_starved` = 0.
  - With reset asserted, `cpu_rdy` follows the `IDLE` equation.
- PPU latency: request in cycle N, data and `ppu_valid` in N+1. Back-to-back requests give back-to-back valids.
- CPU write: 1 cycle when uncontended. Each cycle with `ppu_req` high adds one stall cycle.
- CPU read: 2 cycles when uncontended (grant N with `cpu_rdy`=0, data N+1 with `cpu_rdy`=1), plus one per contended cycle before the grant.
- Simultaneous `ppu_req` and CPU request in `IDLE`: the PPU wins and no RAM write occurs. A CPU write is never issued on a PPU cycle.
- `ppu_req` in `RD_CAP`: served normally; CPU completion is unaffected.
- Reset asserted in `RD_CAP`: the in-flight read is discarded, the FSM returns to `IDLE`, and the next CPU read restarts.
- Continuous `ppu_req`: the CPU stalls indefinitely, with no forced grant. `cpu_starved` rises on the STARVE_LIMIT-th consecutive denied cycle.

## Structure
- Package `vram_pkg`:
  - `VRAM_ADDR_W`, `VRAM_DATA_W` constants.
  - `arb_state_t` enum {`IDLE`, `RD_CAP`}.
- Sub-module `sat_counter` (parameter MAX; ports inc, clr, count, at_max) for the starvation counter.
- Grant, mux and FSM logic live in `vram_arbiter`.
- The RAM is modelled by the existing single-port synchronous RAM.

## Test plan
- Reset mid-read: assert `rst_pix` in `RD_CAP` → state `IDLE`, `ppu_valid`=0, `cpu_rdata`=0. A subsequent read of 0x0100 (RAM=0x5A) completes normally and returns 0x5A.
- Uncontended CPU write: 0x0200←0xA5 with no `ppu_req` → `ram_we`=1 for 1 cycle, `cpu_rdy` never drops. A later uncontended read of 0x0200 → `cpu_rdy` low 1 cycle, then `cpu_rdata`=0xA5 with `cpu_rdy`=1.
- PPU streaming: `ppu_req` on 4 consecutive cycles, addresses 0x1000–0x1003 preloaded 0x10–0x13 → `ppu_valid` high 4 cycles, one later, with data 0x10,0x11,0x12,0x13.
- Contended write: CPU write 0x0300←0x77 with `ppu_req` high for 3 cycles → `cpu_rdy` low 3 cycles, `ram_we` only in cycle 4. RAM[0x0300]=0x77 and PPU data intact.
- Read overlap: CPU read granted, `ppu_req` asserted in the `RD_CAP` cycle → CPU gets correct data that cycle, and the PPU gets `ppu_valid` plus correct data the next cycle.
- Starvation: `cpu_req` and `ppu_req` both high for 20 cycles with STARVE_LIMIT=16 → `cpu_starved` rises in cycle 16. It clears the cycle after `ppu_req` drops and the CPU is granted.
